uart_block_framer: RTL and testbench
====================================

UART_BLOCK_FRAMER -- requirements
Module: uart_block_framer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 24'd500000, idle uart_clock cycles after which a partially assembled RX block is discarded.
REQ-002 uart_clock  input  1  single clock; all state updates on its rising edge.
REQ-003 uart_reset  input  1  synchronous, active-high reset.
REQ-004 uart_received_data  input  8  byte from UART receiver.
REQ-005 uart_rx_valid  input  1  receiver valid level; a new byte is marked by its 0->1 transition.
REQ-006 uart_tx_ready  input  1  transmitter idle and able to accept a start.
REQ-007 uart_transmit_data  output  8  byte presented to UART transmitter.
REQ-008 uart_tx_start  output  1  one-cycle transmit request.
REQ-009 blk_data  output  128  assembled 16-byte block; first received byte in [127:120].
REQ-010 blk_valid  output  1  blk_data valid; held until blk_ready.
REQ-011 blk_ready  input  1  downstream (AES core) accepts blk_data.
REQ-012 res_data  input  128  result block to send; [127:120] sent first.
REQ-013 res_valid  input  1  res_data valid.
REQ-014 res_ready  output  1  framer can accept res_data.
REQ-015 rx_overrun  output  1  one-cycle pulse: byte dropped because blk_valid was pending.
REQ-016 rx_timeout  output  1  one-cycle pulse: partial block discarded.

Function
REQ-017 Byte accept: uart_rx_valid is registered once; a byte is accepted in the cycle where uart_rx_valid=1 and its registered copy=0.
REQ-018 Accepted bytes shift into a 128-bit register from the LSB end (reg <= {reg[119:0], byte}); a 4-bit counter counts 0..15.
REQ-019 On the 16th accepted byte, the counter wraps to 0 and blk_valid=1 from the next cycle, with blk_data equal to the full register.
REQ-020 Handshake: transfer occurs when blk_valid & blk_ready; blk_valid clears the next cycle; blk_data stays stable while blk_valid=1.
REQ-021 A byte accepted while blk_valid=1 is dropped, the counter is unchanged, and rx_overrun pulses.
REQ-022 A byte accepted in the same cycle as the blk transfer is also dropped and flagged as overrun.
REQ-023 An idle counter resets on every accepted byte; when counter!=0 and idle count reaches TIMEOUT_CYCLES, the counter is cleared and rx_timeout pulses; idle counting is disabled at counter=0.
REQ-024 TX FSM states: TX_IDLE, TX_LOAD, TX_START, TX_WAIT_BUSY, TX_WAIT_DONE.
REQ-025 TX_IDLE: res_ready=1; on res_valid, capture res_data into the shift register, clear the byte index, and go to TX_LOAD; res_ready=0 in all other states.
REQ-026 TX_LOAD: uart_transmit_data = shift[127:120]; when uart_tx_ready=1, go to TX_START.
REQ-027 TX_START: uart_tx_start=1 for exactly one cycle with uart_transmit_data held; go to TX_WAIT_BUSY.
REQ-028 TX_WAIT_BUSY: wait for uart_tx_ready=0, then go to TX_WAIT_DONE.
REQ-029 TX_WAIT_DONE: on uart_tx_ready=1, shift the register left 8 and increment the index; after the 16th byte go to TX_IDLE, otherwise go to TX_LOAD.
REQ-030 uart_transmit_data is held stable from TX_LOAD through TX_WAIT_DONE of the same byte.
REQ-031 RX and TX paths are independent; simultaneous RX accept and TX activity are legal.

Reset
REQ-032 Reset values: blk_valid=0, res_ready=0 (1 from the first cycle after reset), uart_tx_start=0, uart_transmit_data=0, rx_overrun=0, rx_timeout=0, blk_data=0, counters=0, edge register=0, state TX_IDLE.
REQ-033 Reset asserted mid-block or mid-transmission aborts immediately; partial data is discarded and no uart_tx_start is issued during reset.

Structure
REQ-034 The TX state enum, BLOCK_BYTES=16, and the byte-index width shall live in the shared package aes_uart_pkg.
REQ-035 The RX assembler is a natural sub-module, uart_block_assembler; the TX serializer stays in the top module.

Verification
REQ-036 Send 16 bytes 00,11,...,ff -> blk_valid=1 with blk_data=128'h00112233445566778899aabbccddeeff; it clears one cycle after blk_ready.
REQ-037 Hold blk_ready=0 and send a 17th byte 0xAA -> rx_overrun pulses once; blk_data is unchanged; the next block assembles from a count of 0.
REQ-038 Send 5 bytes, then idle TIMEOUT_CYCLES (set to 100) -> rx_timeout pulses at cycle 100; the next 16 bytes form a correct block.
REQ-039 res_data=128'h69c4e0d86a7b0430d8cdb78070b4c55a, res_valid=1, UART model busy for 10 cycles per byte -> 16 single-cycle uart_tx_start pulses carrying 69,c4,...,5a in order; res_ready returns to 1.
REQ-040 Assert uart_reset after the 7th TX byte and the 9th RX byte -> all outputs are at reset values; no further uart_tx_start; a fresh block round-trips correctly.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared constants and types for the UART <-> AES block framer.
// Holds the block geometry and the TX serializer state encoding.
package aes_uart_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLK_W       = BLOCK_BYTES * 8;
  localparam int IDX_W       = $clog2(BLOCK_BYTES);

  typedef logic [IDX_W-1:0] byte_idx_t;

  typedef enum logic [2:0] {
    TX_IDLE      = 3'd0,
    TX_LOAD      = 3'd1,
    TX_START     = 3'd2,
    TX_WAIT_BUSY = 3'd3,
    TX_WAIT_DONE = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_block_assembler.sv
// Collects UART RX bytes into a 128-bit block, with overrun flagging
// and an inactivity timeout that discards a partial block.
module uart_block_assembler
  import aes_uart_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd500000
) (
  input  logic             uart_clock,
  input  logic             uart_reset,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  output logic [BLK_W-1:0] blk_data,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             rx_overrun,
  output logic             rx_timeout
);

  logic             rx_valid_q;
  byte_idx_t        cnt_q;
  logic [23:0]      idle_q;
  logic [BLK_W-1:0] shift_q;

  logic accept, take, last, timeout_hit;

  assign accept = rx_valid & ~rx_valid_q;
  // A pending block blocks assembly, including the cycle it is handed off.
  assign take   = accept & ~blk_valid;
  assign last   = (cnt_q == byte_idx_t'(BLOCK_BYTES - 1));
  // A fresh byte wins over an expiring timeout in the same cycle.
  assign timeout_hit = (cnt_q != '0) & ~accept & (idle_q == TIMEOUT_CYCLES - 24'd1);

  assign blk_data = shift_q;

  always_ff @(posedge uart_clock) begin
    if (uart_reset) begin
      rx_valid_q <= 1'b0;
      cnt_q      <= '0;
      idle_q     <= '0;
      shift_q    <= '0;
      blk_valid  <= 1'b0;
      rx_overrun <= 1'b0;
      rx_timeout <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      rx_overrun <= accept & blk_valid;
      rx_timeout <= timeout_hit;

      if (take) begin
        shift_q <= {shift_q[BLK_W-9:0], rx_byte};
        cnt_q   <= last ? '0 : cnt_q + 1'b1;
      end else if (timeout_hit) begin
        cnt_q <= '0;
      end

      if (take && last)
        blk_valid <= 1'b1;
      else if (blk_valid && blk_ready)
        blk_valid <= 1'b0;

      if (accept || cnt_q == '0 || timeout_hit)
        idle_q <= '0;
      else
        idle_q <= idle_q + 24'd1;
    end
  end

endmodule

// File: rtl/uart_block_framer.sv
// Bridges a byte UART to a 128-bit block engine: RX bytes are assembled
// into blocks, result blocks are serialized MSB byte first to the UART TX.
module uart_block_framer
  import aes_uart_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd500000
) (
  input  logic             uart_clock,
  input  logic             uart_reset,
  input  logic [7:0]       uart_received_data,
  input  logic             uart_rx_valid,
  input  logic             uart_tx_ready,
  output logic [7:0]       uart_transmit_data,
  output logic             uart_tx_start,
  output logic [BLK_W-1:0] blk_data,
  output logic             blk_valid,
  input  logic             blk_ready,
  input  logic [BLK_W-1:0] res_data,
  input  logic             res_valid,
  output logic             res_ready,
  output logic             rx_overrun,
  output logic             rx_timeout
);

  uart_block_assembler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .uart_clock (uart_clock),
    .uart_reset (uart_reset),
    .rx_byte    (uart_received_data),
    .rx_valid   (uart_rx_valid),
    .blk_data   (blk_data),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .rx_overrun (rx_overrun),
    .rx_timeout (rx_timeout)
  );

  tx_state_e        state_q;
  logic [BLK_W-1:0] tx_shift_q;
  byte_idx_t        tx_idx_q;

  // Reset gating keeps the handshake outputs quiet while reset is held.
  assign res_ready          = (state_q == TX_IDLE)  & ~uart_reset;
  assign uart_tx_start      = (state_q == TX_START) & ~uart_reset;
  assign uart_transmit_data = tx_shift_q[BLK_W-1 -: 8];

  always_ff @(posedge uart_clock) begin
    if (uart_reset) begin
      state_q    <= TX_IDLE;
      tx_shift_q <= '0;
      tx_idx_q   <= '0;
    end else begin
      unique case (state_q)
        TX_IDLE: if (res_valid) begin
          tx_shift_q <= res_data;
          tx_idx_q   <= '0;
          state_q    <= TX_LOAD;
        end
        TX_LOAD:      if (uart_tx_ready) state_q <= TX_START;
        TX_START:     state_q <= TX_WAIT_BUSY;
        TX_WAIT_BUSY: if (!uart_tx_ready) state_q <= TX_WAIT_DONE;
        TX_WAIT_DONE: if (uart_tx_ready) begin
          tx_shift_q <= {tx_shift_q[BLK_W-9:0], 8'h00};
          tx_idx_q   <= tx_idx_q + 1'b1;
          state_q    <= (tx_idx_q == byte_idx_t'(BLOCK_BYTES - 1)) ? TX_IDLE : TX_LOAD;
        end
        default:      state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_block_framer.sv
// Directed bench for uart_block_framer: RX assembly, overrun, timeout,
// TX serialization against a 10-cycle-busy UART model, and mid-run reset.
module tb_uart_block_framer;

  logic         uart_clock = 1'b0;
  logic         uart_reset = 1'b1;
  logic [7:0]   uart_received_data = '0;
  logic         uart_rx_valid = 1'b0;
  logic         uart_tx_ready;
  logic [7:0]   uart_transmit_data;
  logic         uart_tx_start;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [127:0] res_data = '0;
  logic         res_valid = 1'b0;
  logic         res_ready;
  logic         rx_overrun;
  logic         rx_timeout;

  uart_block_framer #(.TIMEOUT_CYCLES(24'd100)) dut (
    .uart_clock         (uart_clock),
    .uart_reset         (uart_reset),
    .uart_received_data (uart_received_data),
    .uart_rx_valid      (uart_rx_valid),
    .uart_tx_ready      (uart_tx_ready),
    .uart_transmit_data (uart_transmit_data),
    .uart_tx_start      (uart_tx_start),
    .blk_data           (blk_data),
    .blk_valid          (blk_valid),
    .blk_ready          (blk_ready),
    .res_data           (res_data),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .rx_overrun         (rx_overrun),
    .rx_timeout         (rx_timeout)
  );

  always #5 uart_clock = ~uart_clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy = 0;
  int last_acc = 0;

  always @(posedge uart_clock) cyc <= cyc + 1;

  // UART transmitter model: busy for 10 cycles after each start.
  always @(posedge uart_clock)
    if (uart_reset)         busy <= 0;
    else if (uart_tx_start) busy <= 10;
    else if (busy != 0)     busy <= busy - 1;
  assign uart_tx_ready = (busy == 0);

  logic [7:0] tx_log [0:63];
  int tx_cnt = 0, ovr_cnt = 0, tmo_cnt = 0, tmo_cyc = 0;

  always @(negedge uart_clock) begin
    if (uart_tx_start) begin
      if (tx_cnt < 64) tx_log[tx_cnt] = uart_transmit_data;
      tx_cnt = tx_cnt + 1;
    end
    if (rx_overrun) ovr_cnt = ovr_cnt + 1;
    if (rx_timeout) begin
      tmo_cnt = tmo_cnt + 1;
      tmo_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge uart_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_received_data = b;
    uart_rx_valid = 1'b1;
    tick();
    last_acc = cyc;
    uart_rx_valid = 1'b0;
    tick();
  endtask

  task automatic send_seq(input logic [7:0] start, input logic [7:0] step, input int n);
    for (int i = 0; i < n; i++) send_byte(start + 8'(i) * step);
  endtask

  task automatic consume(input string tag);
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    chk(tag, 128'(blk_valid), 128'(1'b0));
  endtask

  task automatic tx_run(input logic [127:0] d, input string tag);
    int base;
    base = tx_cnt;
    res_data = d;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    for (int k = 0; k < 1000 && !(tx_cnt >= base + 16 && res_ready); k++) tick();
    chk({tag, "_done"}, 128'(tx_cnt >= base + 16 && res_ready), 128'(1'b1));
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_byte%0d", tag, i), 128'(tx_log[base + i]), 128'(d[127 - 8*i -: 8]));
    repeat (30) tick();
    chk({tag, "_starts"}, 128'(tx_cnt - base), 128'(16));
    chk({tag, "_res_ready"}, 128'(res_ready), 128'(1'b1));
  endtask

  initial begin
    int o, t, base;

    // Reset values
    repeat (3) tick();
    chk("rst_blk_valid", 128'(blk_valid), 128'(1'b0));
    chk("rst_blk_data", blk_data, 128'h0);
    chk("rst_tx_start", 128'(uart_tx_start), 128'(1'b0));
    chk("rst_tx_data", 128'(uart_transmit_data), 128'h0);
    chk("rst_overrun", 128'(rx_overrun), 128'(1'b0));
    chk("rst_timeout", 128'(rx_timeout), 128'(1'b0));
    chk("rst_res_ready", 128'(res_ready), 128'(1'b0));
    uart_reset = 1'b0;
    tick();
    chk("post_rst_res_ready", 128'(res_ready), 128'(1'b1));

    // Basic block 00,11,..,ff
    send_seq(8'h00, 8'h11, 15);
    chk("a_not_yet", 128'(blk_valid), 128'(1'b0));
    send_byte(8'hff);
    chk("a_valid", 128'(blk_valid), 128'(1'b1));
    chk("a_data", blk_data, 128'h00112233445566778899aabbccddeeff);
    repeat (3) tick();
    chk("a_hold_valid", 128'(blk_valid), 128'(1'b1));
    chk("a_hold_data", blk_data, 128'h00112233445566778899aabbccddeeff);
    consume("a_clear");

    // Overrun while block pending
    send_seq(8'h10, 8'h01, 16);
    chk("b_data", blk_data, 128'h101112131415161718191a1b1c1d1e1f);
    o = ovr_cnt;
    send_byte(8'haa);
    chk("b_overrun", 128'(ovr_cnt - o), 128'(1));
    chk("b_data_kept", blk_data, 128'h101112131415161718191a1b1c1d1e1f);
    chk("b_valid_kept", 128'(blk_valid), 128'(1'b1));
    consume("b_clear");
    send_seq(8'h3c, 8'h05, 16);
    chk("c_valid", 128'(blk_valid), 128'(1'b1));
    chk("c_data", blk_data, 128'h3c41464b50555a5f64696e73787d8287);

    // Byte arriving in the handoff cycle is dropped
    o = ovr_cnt;
    blk_ready = 1'b1;
    uart_received_data = 8'h55;
    uart_rx_valid = 1'b1;
    tick();
    blk_ready = 1'b0;
    uart_rx_valid = 1'b0;
    chk("c_clear", 128'(blk_valid), 128'(1'b0));
    tick();
    chk("c_xfer_overrun", 128'(ovr_cnt - o), 128'(1));
    send_seq(8'ha0, 8'h03, 16);
    chk("d_data", blk_data, 128'ha0a3a6a9acafb2b5b8bbbec1c4c7cacd);
    consume("d_clear");

    // Timeout discards a partial block
    t = tmo_cnt;
    send_seq(8'h77, 8'h01, 5);
    for (int k = 0; k < 300 && tmo_cnt == t; k++) tick();
    repeat (20) tick();
    chk("tmo_count", 128'(tmo_cnt - t), 128'(1));
    chk("tmo_cycle", 128'(tmo_cyc - last_acc), 128'(100));
    send_seq(8'h00, 8'h11, 16);
    chk("tmo_next_data", blk_data, 128'h00112233445566778899aabbccddeeff);
    consume("tmo_next_clear");

    // TX serialization
    tx_run(128'h69c4e0d86a7b0430d8cdb78070b4c55a, "tx");

    // Reset mid-transmission and mid-block
    base = tx_cnt;
    res_data = 128'h000102030405060708090a0b0c0d0e0f;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    send_seq(8'h21, 8'h01, 9);
    for (int k = 0; k < 500 && tx_cnt < base + 7; k++) tick();
    chk("mid_tx_count", 128'(tx_cnt - base), 128'(7));
    for (int i = 0; i < 7; i++)
      chk($sformatf("mid_byte%0d", i), 128'(tx_log[base + i]), 128'(i));
    uart_reset = 1'b1;
    #1;
    chk("mid_rst_start_gated", 128'(uart_tx_start), 128'(1'b0));
    chk("mid_rst_res_ready", 128'(res_ready), 128'(1'b0));
    tick();
    chk("mid_rst_blk_valid", 128'(blk_valid), 128'(1'b0));
    chk("mid_rst_blk_data", blk_data, 128'h0);
    chk("mid_rst_tx_data", 128'(uart_transmit_data), 128'h0);
    chk("mid_rst_tx_start", 128'(uart_tx_start), 128'(1'b0));
    chk("mid_rst_overrun", 128'(rx_overrun), 128'(1'b0));
    chk("mid_rst_timeout", 128'(rx_timeout), 128'(1'b0));
    repeat (2) tick();
    uart_reset = 1'b0;
    repeat (40) tick();
    chk("mid_no_more_starts", 128'(tx_cnt - base), 128'(7));
    chk("mid_res_ready", 128'(res_ready), 128'(1'b1));
    send_seq(8'hf0, 8'hff, 16);
    chk("e_valid", 128'(blk_valid), 128'(1'b1));
    chk("e_data", blk_data, 128'hf0efeeedecebeae9e8e7e6e5e4e3e2e1);
    consume("e_clear");
    tx_run(128'h69c4e0d86a7b0430d8cdb78070b4c55a, "tx2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
